// File: rtl/post_processor_unit.sv
// Final stage of the special-function pipeline: packs a Q4.46 approximation into IEEE FP32/FP16,
// or cleans up skip-path operands (RELU/RELU6/NaN). One register stage, no backpressure.
module post_processor_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        precision,
  input  logic [3:0]  opcode,
  input  logic        sign,
  input  logic [7:0]  exponent,
  input  logic [49:0] approximate_result,
  input  logic        skip,
  input  logic [31:0] single_x,
  output logic        out_valid,
  output logic [31:0] single_y
);

  localparam logic [3:0]  OP_RELU   = 4'h9;
  localparam logic [3:0]  OP_RELU6  = 4'hA;
  localparam logic [31:0] SIX_F32   = 32'h40C0_0000;
  localparam logic [15:0] SIX_F16   = 16'h4600;
  localparam logic [31:0] QNAN_F32  = 32'h7FC0_0000;
  localparam logic [15:0] QNAN_F16  = 16'h7E00;

  logic [31:0] skip_y;
  logic        x_neg;
  logic        x_nan;
  logic        x_gt6;

  always_comb begin
    if (precision) begin
      x_neg = single_x[15];
      x_nan = (single_x[14:10] == 5'h1F) && (single_x[9:0] != 10'd0);
      x_gt6 = !single_x[15] && (single_x[14:0] > SIX_F16[14:0]);
    end else begin
      x_neg = single_x[31];
      x_nan = (single_x[30:23] == 8'hFF) && (single_x[22:0] != 23'd0);
      x_gt6 = !single_x[31] && (single_x[30:0] > SIX_F32[30:0]);
    end

    skip_y = precision ? {16'h0000, single_x[15:0]} : single_x;
    if (x_nan)
      skip_y = precision ? {16'h0000, QNAN_F16} : QNAN_F32;
    else if ((opcode == OP_RELU || opcode == OP_RELU6) && x_neg)
      skip_y = 32'h0000_0000;
    else if (opcode == OP_RELU6 && x_gt6)
      skip_y = precision ? {16'h0000, SIX_F16} : SIX_F32;
  end

  logic               res_sign;
  logic [49:0]        mag;
  logic [5:0]         lead;
  logic [49:0]        norm;
  logic signed [10:0] exp_e;
  logic [22:0]        mant32;
  logic [9:0]         mant16;
  logic               rnd32;
  logic               rnd16;
  logic [23:0]        sum32;
  logic [10:0]        sum16;
  logic signed [10:0] e32;
  logic signed [10:0] e16;
  logic [31:0]        norm_y;

  always_comb begin
    res_sign = sign ^ approximate_result[49];
    // Unsigned negate also yields 2^49 correctly for the most-negative input.
    mag = approximate_result[49] ? (~approximate_result + 50'd1) : approximate_result;

    lead = 6'd0;
    for (int i = 0; i < 50; i++)
      if (mag[i]) lead = i[5:0];

    norm  = mag << (6'd49 - lead);
    exp_e = $signed({3'b000, exponent}) + $signed({5'b00000, lead}) - 11'sd46;

    mant32 = norm[48:26];
    rnd32  = norm[25] && ((|norm[24:0]) || norm[26]);
    sum32  = {1'b0, mant32} + {23'd0, rnd32};
    e32    = exp_e + $signed({10'd0, sum32[23]});

    mant16 = norm[48:39];
    rnd16  = norm[38] && ((|norm[37:0]) || norm[39]);
    sum16  = {1'b0, mant16} + {10'd0, rnd16};
    e16    = exp_e - 11'sd112 + $signed({10'd0, sum16[10]});

    if (precision) begin
      if (mag == 50'd0 || e16 <= 11'sd0)
        norm_y = {16'h0000, res_sign, 15'h0000};
      else if (e16 >= 11'sd31)
        norm_y = {16'h0000, res_sign, 5'h1F, 10'h000};
      else
        norm_y = {16'h0000, res_sign, e16[4:0], sum16[9:0]};
    end else begin
      if (mag == 50'd0 || e32 <= 11'sd0)
        norm_y = {res_sign, 31'h0000_0000};
      else if (e32 >= 11'sd255)
        norm_y = {res_sign, 8'hFF, 23'h00_0000};
      else
        norm_y = {res_sign, e32[7:0], sum32[22:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      single_y  <= 32'h0000_0000;
    end else begin
      out_valid <= in_valid;
      if (in_valid)
        single_y <= skip ? skip_y : norm_y;
    end
  end

endmodule

// File: tb/tb_post_processor_unit.sv
// Directed bench for post_processor_unit: hand-computed vectors for skip path, FP32/FP16 packing,
// rounding, range limits, hold behaviour and asynchronous reset.
module tb_post_processor_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        precision;
  logic [3:0]  opcode;
  logic        sign;
  logic [7:0]  exponent;
  logic [49:0] approximate_result;
  logic        skip;
  logic [31:0] single_x;
  logic        out_valid;
  logic [31:0] single_y;

  int n_checks = 0;
  int n_fail   = 0;

  post_processor_unit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid           (in_valid),
    .precision          (precision),
    .opcode             (opcode),
    .sign               (sign),
    .exponent           (exponent),
    .approximate_result (approximate_result),
    .skip               (skip),
    .single_x           (single_x),
    .out_valid          (out_valid),
    .single_y           (single_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one operation at the falling edge, then sample just after the capturing edge.
  task automatic op(input logic v, input logic p, input logic skp, input logic [3:0] opc,
                    input logic s, input logic [7:0] e, input logic [49:0] ar,
                    input logic [31:0] x);
    @(negedge clk);
    in_valid           = v;
    precision          = p;
    skip               = skp;
    opcode             = opc;
    sign               = s;
    exponent           = e;
    approximate_result = ar;
    single_x           = x;
    @(posedge clk);
    #1;
  endtask

  task automatic skp32(input string tag, input logic [3:0] opc, input logic [31:0] x,
                       input logic [31:0] exp);
    op(1'b1, 1'b0, 1'b1, opc, 1'b0, 8'h00, 50'd0, x);
    chk(tag, single_y, exp);
  endtask

  task automatic skp16(input string tag, input logic [3:0] opc, input logic [31:0] x,
                       input logic [31:0] exp);
    op(1'b1, 1'b1, 1'b1, opc, 1'b0, 8'h00, 50'd0, x);
    chk(tag, single_y, exp);
  endtask

  task automatic nrm(input string tag, input logic p, input logic s, input logic [7:0] e,
                     input logic [49:0] ar, input logic [31:0] exp);
    op(1'b1, p, 1'b0, 4'h0, s, e, ar, 32'hDEAD_BEEF);
    chk(tag, single_y, exp);
  endtask

  initial begin
    logic [49:0] t;
    rst_n = 1'b0; in_valid = 1'b0; precision = 1'b0; opcode = 4'h0; sign = 1'b0;
    exponent = 8'h00; approximate_result = 50'd0; skip = 1'b0; single_x = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_y", single_y, 32'h0);
    chk("reset_valid", {31'd0, out_valid}, 32'd1 - 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Skip path
    skp32("relu6_denorm", 4'hA, 32'h0000_53B7, 32'h0000_53B7);
    chk("relu6_denorm_valid", {31'd0, out_valid}, 32'd1);
    skp32("relu6_8", 4'hA, 32'h4100_0000, 32'h40C0_0000);
    skp32("relu_neg1", 4'h9, 32'hBF80_0000, 32'h0000_0000);
    skp32("relu6_neg2", 4'hA, 32'hC000_0000, 32'h0000_0000);
    skp32("relu6_exact6", 4'hA, 32'h40C0_0000, 32'h40C0_0000);
    skp32("relu6_inf", 4'hA, 32'h7F80_0000, 32'h40C0_0000);
    skp32("relu_pos", 4'h9, 32'h3FC0_0000, 32'h3FC0_0000);
    skp32("sqrt_nan", 4'h2, 32'h7F80_0001, 32'h7FC0_0000);
    skp32("relu_negnan", 4'h9, 32'hFFC0_1234, 32'h7FC0_0000);
    skp32("reserved_pass", 4'hF, 32'hC120_0000, 32'hC120_0000);
    skp16("f16_relu6_8", 4'hA, 32'h0000_4800, 32'h0000_4600);
    skp16("f16_nan", 4'h5, 32'h0000_7C01, 32'h0000_7E00);
    skp16("f16_pass_upper", 4'h0, 32'hABCD_3C00, 32'h0000_3C00);
    skp16("f16_relu_neg", 4'h9, 32'h0000_BC00, 32'h0000_0000);

    // Normal path FP32
    nrm("one", 1'b0, 1'b0, 8'h7F, 50'h0400000000000, 32'h3F80_0000);
    t = 50'h0600000000000;
    nrm("neg_1p5", 1'b0, 1'b0, 8'h80, -t, 32'hC040_0000);
    nrm("ovf_inf", 1'b0, 1'b0, 8'hFE, 50'h0800000000000, 32'h7F80_0000);
    nrm("zero", 1'b0, 1'b0, 8'h7F, 50'd0, 32'h0000_0000);
    nrm("neg_zero", 1'b0, 1'b1, 8'h7F, 50'd0, 32'h8000_0000);
    nrm("tie_even", 1'b0, 1'b0, 8'h7F, (50'd1 << 46) | (50'd1 << 22), 32'h3F80_0000);
    nrm("tie_sticky", 1'b0, 1'b0, 8'h7F, (50'd1 << 46) | (50'd1 << 22) | 50'd1, 32'h3F80_0001);
    nrm("tie_odd", 1'b0, 1'b0, 8'h7F, (50'd1 << 46) | (50'd1 << 23) | (50'd1 << 22), 32'h3F80_0002);
    nrm("round_carry", 1'b0, 1'b0, 8'h7F, (50'd1 << 47) - (50'd1 << 21), 32'h4000_0000);
    nrm("flush_zero", 1'b0, 1'b1, 8'h00, 50'h0400000000000, 32'h8000_0000);
    nrm("min_normal", 1'b0, 1'b0, 8'h01, 50'h0400000000000, 32'h0080_0000);
    nrm("most_neg", 1'b0, 1'b0, 8'h7F, 50'h2000000000000, 32'hC100_0000);
    nrm("lsb_only", 1'b0, 1'b0, 8'h7F, 50'd1, 32'h2880_0000);
    nrm("sign_in", 1'b0, 1'b1, 8'h7F, 50'h0400000000000, 32'hBF80_0000);

    // Normal path FP16
    nrm("f16_one", 1'b1, 1'b0, 8'h7F, 50'h0400000000000, 32'h0000_3C00);
    nrm("f16_max_exp", 1'b1, 1'b0, 8'h8E, 50'h0400000000000, 32'h0000_7800);
    nrm("f16_inf", 1'b1, 1'b1, 8'h8F, 50'h0400000000000, 32'h0000_FC00);
    nrm("f16_flush", 1'b1, 1'b0, 8'h70, 50'h0400000000000, 32'h0000_0000);
    nrm("f16_round", 1'b1, 1'b0, 8'h7F, (50'd1 << 46) | (50'd1 << 35) | 50'd1, 32'h0000_3C01);

    // Hold when idle
    op(1'b0, 1'b0, 1'b1, 4'h9, 1'b0, 8'h00, 50'd0, 32'h1234_5678);
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_hold", single_y, 32'h0000_3C01);

    // Reset mid-stream with an operation about to be captured
    nrm("pre_reset", 1'b0, 1'b0, 8'h7F, 50'h0400000000000, 32'h3F80_0000);
    @(negedge clk);
    in_valid = 1'b1; skip = 1'b1; opcode = 4'h0; precision = 1'b0; single_x = 32'h4049_0FDB;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_y", single_y, 32'h0);
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("in_rst_y", single_y, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_y", single_y, 32'h0);
    skp32("post_rst_first", 4'h0, 32'h4049_0FDB, 32'h4049_0FDB);
    chk("post_rst_first_valid", {31'd0, out_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
